// File: rtl/muldiv_sequencer.sv
// Unsigned shift-add multiply / restoring divide on the shared ALU, one bit per cycle; done WIDTH+1 edges after start, busy stalls the pipe.
// Divide by zero finishes right away; MULDIV_EARLY_OUT_EN also finishes trivial mul/div without iterating.
module muldiv_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter logic [2:0] OP_SUB = 3'b001
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero,
  output logic [WIDTH-1:0] aluInA,
  output logic [WIDTH-1:0] aluInB,
  output logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] aluResult
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT            state, stateNxt;
  logic [WIDTH-1:0] hiNxt, loNxt, opnd, opndNxt;
  logic [CW-1:0]    cnt, cntNxt;
  logic             dbzNxt;
  logic             carry;
  logic [WIDTH-1:0] sum, rem;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      cnt       <= '0;
      divByZero <= 1'b0;
    end else begin
      state     <= stateNxt;
      hi        <= hiNxt;
      lo        <= loNxt;
      opnd      <= opndNxt;
      cnt       <= cntNxt;
      divByZero <= dbzNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    hiNxt    = hi;
    loNxt    = lo;
    opndNxt  = opnd;
    cntNxt   = cnt;
    dbzNxt   = divByZero;
    aluInA   = '0;
    aluInB   = '0;
    aluOp    = OP_ADD;
    carry    = 1'b0;
    sum      = '0;
    rem      = '0;
    busy     = (state == MUL) || (state == DIV);
    done     = (state == DONE);

    case (state)
      IDLE, DONE: begin
        stateNxt = IDLE;
        if (start) begin
          cntNxt = '0;
          dbzNxt = 1'b0;
          if (!isDiv) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (opA == '0 || opB == '0) begin
              hiNxt    = '0;
              loNxt    = '0;
              stateNxt = DONE;
            end else
`endif
            begin
              hiNxt    = '0;
              loNxt    = opA;
              opndNxt  = opB;
              stateNxt = MUL;
            end
          end else if (opB == '0) begin
            hiNxt    = opA;
            loNxt    = '1;
            dbzNxt   = 1'b1;
            stateNxt = DONE;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (opA < opB) begin
            hiNxt    = opA;
            loNxt    = '0;
            stateNxt = DONE;
          end
`endif
          else begin
            hiNxt    = '0;
            loNxt    = opA;
            opndNxt  = opB;
            stateNxt = DIV;
          end
        end
      end

      MUL: begin
        aluOp  = OP_ADD;
        aluInA = hi;
        aluInB = opnd;
        // Wrap-around of the 32-bit add reveals the carry into the product's upper bit.
        carry  = lo[0] & (aluResult < hi);
        sum    = lo[0] ? aluResult : hi;
        hiNxt  = {carry, sum[WIDTH-1:1]};
        loNxt  = {sum[0], lo[WIDTH-1:1]};
        cntNxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) stateNxt = DONE;
      end

      DIV: begin
        rem    = {hi[WIDTH-2:0], lo[WIDTH-1]};
        aluOp  = OP_SUB;
        aluInA = rem;
        aluInB = opnd;
        // A set bit shifted out of hi means the true remainder exceeds any divisor.
        if (hi[WIDTH-1] || (rem >= opnd)) begin
          hiNxt = aluResult;
          loNxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
          hiNxt = rem;
          loNxt = {lo[WIDTH-2:0], 1'b0};
        end
        cntNxt = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) stateNxt = DONE;
      end

      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vectors, corner sequences and random ops against an arithmetic reference.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rstN, start, isDiv;
  logic [31:0] opA, opB;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo, aluInA, aluInB, aluResult;
  logic [2:0]  aluOp;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  // Shared ALU stand-in.
  assign aluResult = (aluOp == 3'b000) ? aluInA + aluInB :
                     (aluOp == 3'b001) ? aluInA - aluInB : 32'h0;

  muldiv_sequencer dut (
    .clk(clk), .rstN(rstN), .start(start), .isDiv(isDiv), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(divByZero),
    .aluInA(aluInA), .aluInB(aluInB), .aluOp(aluOp), .aluResult(aluResult)
  );

  typedef struct {
    logic        isDiv;
    logic [31:0] a, b, expHi, expLo;
    logic        expDbz;
  } vecT;

  vecT vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int expLatency(input logic d, input logic [31:0] a, input logic [31:0] b);
    if (d && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!d && (a == 0 || b == 0)) return 1;
    if (d && a < b) return 1;
`endif
    return 33;
  endfunction

  // Latency counts edges from the accepting edge (inclusive) until done is seen.
  task automatic runOp(input logic d, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rHi, output logic [31:0] rLo, output logic rDbz,
                       output int lat, output int busyCnt);
    @(negedge clk);
    start = 1'b1; isDiv = d; opA = a; opB = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busyCnt = 0;
    while (!done && lat < 100) begin
      if (busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    rHi = hi; rLo = lo; rDbz = divByZero;
  endtask

  initial begin
    logic [31:0] rHi, rLo, a, b;
    logic        rDbz, d;
    logic [63:0] prod;
    int          lat, busyCnt, eLat, doneSeen;
    string       tag;

    vecs[0] = '{1'b0, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1'b0, 32'd0,         32'd9,         32'h0,         32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'd3,         32'd8,         32'd3,         32'h0,         1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};

    rstN = 1'b0; start = 1'b0; isDiv = 1'b0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst dbz", divByZero, 0);
    check("rst alu", {aluOp, aluInA, aluInB}, 0);
    rstN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].isDiv, vecs[i].a, vecs[i].b, rHi, rLo, rDbz, lat, busyCnt);
      eLat = expLatency(vecs[i].isDiv, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d hi", i), rHi, vecs[i].expHi);
      check($sformatf("vec%0d lo", i), rLo, vecs[i].expLo);
      check($sformatf("vec%0d dbz", i), rDbz, vecs[i].expDbz);
      check($sformatf("vec%0d latency", i), lat, eLat);
      check($sformatf("vec%0d busy cycles", i), busyCnt, eLat - 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse", i), done, 0);
      check($sformatf("vec%0d hold", i), {hi, lo}, {vecs[i].expHi, vecs[i].expLo});
      check($sformatf("vec%0d idle alu", i), {aluOp, aluInA, aluInB}, 0);
    end

    // divByZero stays set until the next accepted start clears it.
    runOp(1'b1, 32'd9, 32'd0, rHi, rLo, rDbz, lat, busyCnt);
    repeat (3) @(posedge clk);
    #1 check("dbz held", divByZero, 1);

    // Back-to-back: second start arrives while done is high.
    runOp(1'b0, 32'd6, 32'd7, rHi, rLo, rDbz, lat, busyCnt);
    check("b2b first lo", rLo, 32'h2A);
    check("b2b first dbz cleared", rDbz, 0);
    runOp(1'b1, 32'd100, 32'd7, rHi, rLo, rDbz, lat, busyCnt);
    check("b2b second result", {rHi, rLo}, {32'd2, 32'd14});
    check("b2b second latency", lat, 33);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; opA = 32'd3; opB = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        start = 1'b1; isDiv = 1'b1; opA = 32'd9; opB = 32'd3;
      end else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("ignore result", {hi, lo}, {32'd0, 32'd12});
    check("ignore latency", lat, expLatency(1'b0, 32'd3, 32'd4));
    check("ignore dbz", divByZero, 0);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1; isDiv = 1'b0; opA = 32'd3; opB = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    check("midrst outputs", {busy, done, divByZero, hi, lo}, 0);
    check("midrst alu", {aluOp, aluInA, aluInB}, 0);
    @(negedge clk);
    rstN = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen++;
    end
    check("midrst no done", doneSeen, 0);

    // Random operations against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 300); b = $urandom_range(0, 20); end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = $urandom_range(0, 1) ? 32'd0 : $urandom; end
        default: begin a = $urandom; b = $urandom_range(1, 1000); end
      endcase
      runOp(d, a, b, rHi, rLo, rDbz, lat, busyCnt);
      tag = $sformatf("rnd%0d %s 0x%0h,0x%0h", i, d ? "div" : "mul", a, b);
      if (!d) begin
        prod = 64'(a) * 64'(b);
        check({tag, " result"}, {rHi, rLo}, prod);
        check({tag, " dbz"}, rDbz, 0);
      end else if (b == 0) begin
        check({tag, " result"}, {rHi, rLo}, {a, 32'hFFFF_FFFF});
        check({tag, " dbz"}, rDbz, 1);
      end else begin
        check({tag, " result"}, {rHi, rLo}, {a % b, a / b});
        check({tag, " dbz"}, rDbz, 0);
      end
      check({tag, " latency"}, lat, expLatency(d, a, b));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
